// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 800x600@60 timing constants, counter widths and pattern select type
package vga_timing_pkg;
    localparam int VGA_H_VISIBLE = 800;
    localparam int VGA_H_FRONT   = 40;
    localparam int VGA_H_SYNC    = 128;
    localparam int VGA_H_BACK    = 88;
    localparam int VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int VGA_V_VISIBLE = 600;
    localparam int VGA_V_FRONT   = 1;
    localparam int VGA_V_SYNC    = 4;
    localparam int VGA_V_BACK    = 23;
    localparam int VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
    localparam logic VGA_SYNC_POL = 1'b1;
    localparam int HW = 11;
    localparam int VW = 10;
    typedef enum logic {PAT_BARS = 1'b0, PAT_CHECK = 1'b1} pat_e;
endpackage

// File: rtl/vga_timing_counter.sv
// vga_timing_counter: horizontal/vertical pixel counters with raw (unregistered) sync, blank and frame start
// Ports:
//   clk, reset_n     pixel clock, asynchronous active-low reset
//   hcnt_o, vcnt_o   current pixel column / line
//   frame_start_o    high while the counters sit at pixel (0,0)
//   hs_o, vs_o       raw syncs at SYNC_POL when active
//   blank_o          raw blank, 1 outside the visible area
module vga_timing_counter
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = VGA_H_VISIBLE,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_VISIBLE = VGA_V_VISIBLE,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter logic SYNC_POL  = VGA_SYNC_POL
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [HW-1:0] hcnt_o,
    output logic [VW-1:0] vcnt_o,
    output logic          frame_start_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          blank_o
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          h_last, v_last;
    always_comb begin
        h_last        = hcnt_q == HW'(H_TOTAL - 1);
        v_last        = vcnt_q == VW'(V_TOTAL - 1);
        hcnt_d        = h_last ? '0 : hcnt_q + 1'b1;
        vcnt_d        = !h_last ? vcnt_q : (v_last ? '0 : vcnt_q + 1'b1);
        frame_start_o = hcnt_q == '0 && vcnt_q == '0;
        hs_o          = (hcnt_q >= HW'(H_VISIBLE + H_FRONT) &&
                         hcnt_q <  HW'(H_VISIBLE + H_FRONT + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
        vs_o          = (vcnt_q >= VW'(V_VISIBLE + V_FRONT) &&
                         vcnt_q <  VW'(V_VISIBLE + V_FRONT + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
        blank_o       = !(hcnt_q < HW'(H_VISIBLE) && vcnt_q < VW'(V_VISIBLE));
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end
    assign hcnt_o = hcnt_q;
    assign vcnt_o = vcnt_q;
endmodule

// File: rtl/vga_2bit_pattern_gen.sv
// vga_2bit_pattern_gen: 800x600@60 VGA timing with colour-bar / ramp-checker test pattern, 2 bits per channel
// Ports:
//   clk, reset_n   40 MHz pixel clock, asynchronous active-low reset
//   Hs, Vs         registered syncs (SYNC_POL when active)
//   Blank          registered blank, 1 = blanking interval
//   R, G, B        registered 2-bit colour levels, 0 while blanked
//   SEL            pattern select, taken only at frame start (0 = bars, 1 = ramp/checker)
// Option: define VGA_SEL_SYNC_EN to pass SEL through a 2-flop synchronizer first.
module vga_2bit_pattern_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_VISIBLE = VGA_H_VISIBLE,
    parameter int   H_FRONT   = VGA_H_FRONT,
    parameter int   H_SYNC    = VGA_H_SYNC,
    parameter int   H_BACK    = VGA_H_BACK,
    parameter int   V_VISIBLE = VGA_V_VISIBLE,
    parameter int   V_FRONT   = VGA_V_FRONT,
    parameter int   V_SYNC    = VGA_V_SYNC,
    parameter int   V_BACK    = VGA_V_BACK,
    parameter logic SYNC_POL  = VGA_SYNC_POL
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       Hs,
    output logic       Vs,
    output logic       Blank,
    output logic [1:0] R,
    output logic [1:0] G,
    output logic [1:0] B,
    input  logic       SEL
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int BAR_W   = H_VISIBLE / 8;
    localparam int BW      = $clog2(BAR_W + 1);
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          frame_start, hs_raw, vs_raw, blank_raw;
    logic          sel_src, vcnt_unused, bar_end, line_end;
    pat_e          sel_q, sel_d;
    logic [2:0]    bar_q, bar_d;
    logic [BW-1:0] bpix_q, bpix_d;
    logic          hs_q, vs_q, blank_q;
    logic [1:0]    r_q, g_q, b_q, r_d, g_d, b_d;
    vga_timing_counter #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
        .SYNC_POL(SYNC_POL)
    ) u_cnt (
        .clk(clk), .reset_n(reset_n), .hcnt_o(hcnt), .vcnt_o(vcnt),
        .frame_start_o(frame_start), .hs_o(hs_raw), .vs_o(vs_raw), .blank_o(blank_raw)
    );
    assign vcnt_unused = ^{vcnt[VW-1:8], vcnt[5:0]};
`ifdef VGA_SEL_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[0], SEL};
    end
    assign sel_src = sync_q[1];
`else
    assign sel_src = SEL;
`endif
    // bar_q tracks hcnt / BAR_W using a per-bar pixel counter; it keeps wrapping
    // past the visible area, which is harmless because RGB is blanked there.
    always_comb begin
        sel_d    = frame_start ? pat_e'(sel_src) : sel_q;
        line_end = hcnt == HW'(H_TOTAL - 1);
        bar_end  = bpix_q == BW'(BAR_W - 1);
        bpix_d   = (line_end || bar_end) ? '0 : bpix_q + 1'b1;
        bar_d    = line_end ? '0 : bar_q + {2'b00, bar_end};
        r_d      = blank_raw ? 2'b00 : (sel_d == PAT_CHECK) ? hcnt[7:6] : {2{bar_q[2]}};
        g_d      = blank_raw ? 2'b00 : (sel_d == PAT_CHECK) ? vcnt[7:6] : {2{bar_q[1]}};
        b_d      = blank_raw ? 2'b00 : (sel_d == PAT_CHECK) ? {2{hcnt[6] ^ vcnt[6]}} : {2{bar_q[0]}};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q   <= PAT_BARS;
            bar_q   <= '0;
            bpix_q  <= '0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            blank_q <= 1'b1;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            sel_q   <= sel_d;
            bar_q   <= bar_d;
            bpix_q  <= bpix_d;
            hs_q    <= hs_raw;
            vs_q    <= vs_raw;
            blank_q <= blank_raw;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end
    assign Hs    = hs_q;
    assign Vs    = vs_q;
    assign Blank = blank_q;
    assign R     = r_q;
    assign G     = g_q;
    assign B     = b_q;
endmodule

// File: tb/tb_vga_2bit_pattern_gen.sv
// tb_vga_2bit_pattern_gen: directed vector table plus line/frame timing sequences for vga_2bit_pattern_gen
module tb_vga_2bit_pattern_gen;
    localparam int HT = 1056;
    logic       clk = 1'b0, reset_n = 1'b0, sel = 1'b0, sel_s = 1'b0;
    logic       hs, vs, blank, hs_s, vs_s, blank_s;
    logic [1:0] r, g, b, r_s, g_s, b_s;
    int         pass_cnt = 0, total = 0;

    typedef struct {
        logic       sel;
        int         h;
        int         v;
        logic [8:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    vga_2bit_pattern_gen dut (
        .clk(clk), .reset_n(reset_n), .Hs(hs), .Vs(vs), .Blank(blank),
        .R(r), .G(g), .B(b), .SEL(sel)
    );
    // short vertical timing so whole frames fit in a short run
    vga_2bit_pattern_gen #(.V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .Hs(hs_s), .Vs(vs_s), .Blank(blank_s),
        .R(r_s), .G(g_s), .B(b_s), .SEL(sel_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add(input logic s, input int h, input int v, input logic [8:0] e, input string n);
        vec_t t;
        t.sel = s; t.h = h; t.v = v; t.exp = e; t.name = n;
        vecs.push_back(t);
    endtask

    // Leaves the bench on the negedge where pixel (0,0) is being shown.
    task automatic do_reset(input logic s);
        int n;
        sel = s;
        sel_s = s;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("reset_state", {hs, vs, blank, r, g, b}, 9'h040);
        @(negedge clk);
        chk("reset_state_held", {hs, vs, blank, r, g, b}, 9'h040);
        reset_n = 1'b1;
        n = 0;
        while (blank && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("first_pixel_latency", int'(!blank && n >= 1 && n <= 2), 1);
    endtask

    initial begin
        int cur, idx, hs_rise, hs_len, blank_low, next_start, vs_rise, vs_len;
        logic cur_sel;
        bit have;
        // {Hs, Vs, Blank, R, G, B}
        add(0,    0, 0, 9'h000, "bars_px0_black");
        add(0,   99, 0, 9'h000, "bars_px99_black");
        add(0,  100, 0, 9'h003, "bars_px100_blue");
        add(0,  150, 0, 9'h003, "bars_px150_blue");
        add(0,  199, 0, 9'h003, "bars_px199_blue");
        add(0,  200, 0, 9'h00C, "bars_px200_green");
        add(0,  450, 0, 9'h030, "bars_px450_red");
        add(0,  750, 0, 9'h03F, "bars_px750_white");
        add(0,  799, 0, 9'h03F, "bars_px799_white");
        add(0,  800, 0, 9'h040, "hblank_px800");
        add(0,  839, 0, 9'h040, "hs_before");
        add(0,  840, 0, 9'h140, "hs_first");
        add(0,  967, 0, 9'h140, "hs_last");
        add(0,  968, 0, 9'h040, "hs_after");
        add(0, 1055, 0, 9'h040, "line_last_px");
        add(0,  350, 1, 9'h00F, "bars_l1_cyan");
        add(0,  650, 1, 9'h03C, "bars_l1_yellow");
        add(1,   64, 0, 9'h013, "check_px64");
        add(1,  128, 0, 9'h020, "check_px128");
        add(1,  255, 0, 9'h033, "check_px255");
        add(1,  850, 0, 9'h140, "check_hblank");
        add(1,    0, 1, 9'h000, "check_l1_px0");
        add(1,  192, 1, 9'h033, "check_l1_px192");
        have = 0;
        cur = 0;
        cur_sel = 1'b0;
        foreach (vecs[k]) begin
            idx = vecs[k].v * HT + vecs[k].h;
            if (!have || vecs[k].sel != cur_sel || idx < cur) begin
                do_reset(vecs[k].sel);
                cur_sel = vecs[k].sel;
                cur = 0;
                have = 1;
            end
            repeat (idx - cur) @(negedge clk);
            cur = idx;
            chk(vecs[k].name, {hs, vs, blank, r, g, b}, vecs[k].exp);
        end

        // line timing over two lines
        do_reset(1'b0);
        hs_rise = -1; hs_len = 0; blank_low = 0; next_start = -1;
        for (int i = 0; i < 2 * HT; i++) begin
            if (i > 0) @(negedge clk);
            if (i < HT) begin
                if (hs && hs_rise < 0) hs_rise = i;
                if (hs) hs_len++;
                if (!blank) blank_low++;
            end else if (!blank && next_start < 0) next_start = i;
        end
        chk("hs_start", hs_rise, 840);
        chk("hs_width", hs_len, 128);
        chk("blank_low_per_line", blank_low, 800);
        chk("line_period", next_start, HT);

        // short-frame DUT: vertical timing, frame wrap and mid-frame pattern switch
        do_reset(1'b0);
        vs_rise = -1; vs_len = 0; blank_low = 0; next_start = -1;
        for (int i = 0; i <= 8 * HT + 5 * HT + 100; i++) begin
            if (i > 0) @(negedge clk);
            if (i == HT + 10) sel_s = 1'b1;
            if (i < 8 * HT) begin
                if (vs_s && vs_rise < 0) vs_rise = i;
                if (vs_s) vs_len++;
                if (!blank_s) blank_low++;
            end else if (!blank_s && next_start < 0) next_start = i;
            if (i == 2 * HT + 450) chk("switch_holds_bars", {hs_s, vs_s, blank_s, r_s, g_s, b_s}, 9'h030);
            if (i == 4 * HT + 450) chk("vblank_line_rgb0", {hs_s, vs_s, blank_s, r_s, g_s, b_s}, 9'h040);
            if (i == 8 * HT + 64) chk("switch_next_frame", {hs_s, vs_s, blank_s, r_s, g_s, b_s}, 9'h013);
            if (i == 8 * HT + 5 * HT + 100) chk("vs_frame1", {hs_s, vs_s, blank_s, r_s, g_s, b_s}, 9'h0C0);
        end
        chk("vs_start", vs_rise, 5 * HT);
        chk("vs_width", vs_len, 2 * HT);
        chk("blank_low_per_frame", blank_low, 800 * 4);
        chk("frame_period", next_start, 8 * HT);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
